// File: rtl/commit_trace_buffer.sv
// ---------------------------------------------------------------------------
// commit_trace_buffer
//
// Snoops the write-back stage of the pipeline and records retiring PCs into a
// circular trace buffer. A PC-match or exception trigger freezes the buffer
// POST_DEPTH commits after the trigger instruction. This keeps the history
// leading up to a fault available for readout through an indexed port.
//
// Parameters:
//   DEPTH      - number of trace entries (power of two, 4..256)
//   PC_W       - width of the captured PC
//   POST_DEPTH - commits captured after the trigger entry (0..DEPTH-1)
//   AW         - derived index width, log2(DEPTH)
//
// Ports:
//   clk          - single clock, rising-edge active
//   resetn       - asynchronous active-low reset
//   wb_valid     - a valid instruction retires this cycle
//   wb_pc        - PC of the retiring instruction
//   wb_excp      - the retiring instruction raised an exception
//   arm          - pulse: clear the buffer and start capture
//   stop         - pulse: force DONE (ignored in IDLE, loses to arm)
//   trig_pc      - PC-match trigger value
//   trig_pc_en   - enables the PC-match trigger
//   trig_excp_en - enables the exception trigger
//   rd_idx       - readout index, 0 is the oldest entry
//   rd_pc        - registered PC of entry rd_idx (0 when out of range)
//   rd_stamp     - registered cycle stamp of entry rd_idx (0 when disabled)
//   state        - 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   entry_cnt    - number of valid entries, 0..DEPTH
//   trig_seen    - a trigger has fired since the last arm
//
// Configuration macro:
//   TRACE_CYCLE_STAMP_EN - builds a free-running 16-bit cycle counter whose
//                          value is stored with every entry and returned on
//                          rd_stamp. Without it rd_stamp is tied to 0.
// ---------------------------------------------------------------------------
module commit_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int PC_W       = 32,
    parameter int POST_DEPTH = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wb_valid,
    input  logic [PC_W-1:0] wb_pc,
    input  logic            wb_excp,
    input  logic            arm,
    input  logic            stop,
    input  logic [PC_W-1:0] trig_pc,
    input  logic            trig_pc_en,
    input  logic            trig_excp_en,
    input  logic [AW-1:0]   rd_idx,
    output logic [PC_W-1:0] rd_pc,
    output logic [15:0]     rd_stamp,
    output logic [1:0]      state,
    output logic [AW:0]     entry_cnt,
    output logic            trig_seen
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

    state_t          cur_state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   post_left;
    logic [AW-1:0]   rd_phys;
    logic            active;
    logic            capture;
    logic            trigger;
    logic            stop_ok;
    logic            in_range;

    // Trace storage; contents are deliberately not reset.
    logic [PC_W-1:0] pc_mem [DEPTH];

    assign state = cur_state;

    always_comb begin
        active   = (cur_state == ARMED) || (cur_state == POST);
        // arm and stop both suppress the capture of their own cycle.
        capture  = wb_valid && active && !arm && !stop;
        trigger  = capture && (cur_state == ARMED) &&
                   ((trig_pc_en && (wb_pc == trig_pc)) ||
                    (trig_excp_en && wb_excp));
        stop_ok  = stop && (cur_state != IDLE);
        // When the buffer is full the low AW bits of entry_cnt are zero, so
        // the oldest entry is simply the one at wr_ptr.
        rd_phys  = wr_ptr - entry_cnt[AW-1:0] + rd_idx;
        in_range = ({1'b0, rd_idx} < entry_cnt);
    end

    // Control FSM, pointers and counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state <= IDLE;
            wr_ptr    <= '0;
            entry_cnt <= '0;
            trig_seen <= 1'b0;
            post_left <= '0;
        end else if (arm) begin
            cur_state <= ARMED;
            wr_ptr    <= '0;
            entry_cnt <= '0;
            trig_seen <= 1'b0;
            post_left <= '0;
        end else if (stop_ok) begin
            cur_state <= DONE;
        end else if (capture) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (entry_cnt != CNT_FULL) begin
                entry_cnt <= entry_cnt + CNT_ONE;
            end
            if (trigger) begin
                trig_seen <= 1'b1;
                post_left <= POST_LOAD;
                if (POST_DEPTH == 0) begin
                    cur_state <= DONE;
                end else begin
                    cur_state <= POST;
                end
            end else if (cur_state == POST) begin
                post_left <= post_left - PTR_ONE;
                if (post_left == PTR_ONE) begin
                    cur_state <= DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            pc_mem[wr_ptr] <= wb_pc;
        end
    end

    // Registered readout, one cycle of latency from rd_idx.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pc <= '0;
        end else if (in_range) begin
            rd_pc <= pc_mem[rd_phys];
        end else begin
            rd_pc <= '0;
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0] cycle_cnt;
    logic [15:0] stamp_mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt <= '0;
            rd_stamp  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
            if (in_range) begin
                rd_stamp <= stamp_mem[rd_phys];
            end else begin
                rd_stamp <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            stamp_mem[wr_ptr] <= cycle_cnt;
        end
    end
`else
    assign rd_stamp = '0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        wb_excp = 1'b0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        trig_pc_en = 1'b0;
    logic        trig_excp_en = 1'b0;
    logic [3:0]  rd_idx = '0;

    logic [31:0] rd_pc0, rd_pc1;
    logic [15:0] rd_stamp0, rd_stamp1;
    logic [1:0]  state0, state1;
    logic [4:0]  entry_cnt0, entry_cnt1;
    logic        trig_seen0, trig_seen1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(16), .PC_W(32), .POST_DEPTH(4)) u_dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_excp(wb_excp), .arm(arm), .stop(stop), .trig_pc(trig_pc),
        .trig_pc_en(trig_pc_en), .trig_excp_en(trig_excp_en), .rd_idx(rd_idx),
        .rd_pc(rd_pc0), .rd_stamp(rd_stamp0), .state(state0),
        .entry_cnt(entry_cnt0), .trig_seen(trig_seen0)
    );

    // Same stimulus, no post-trigger window.
    commit_trace_buffer #(.DEPTH(16), .PC_W(32), .POST_DEPTH(0)) u_dut_p0 (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_excp(wb_excp), .arm(arm), .stop(stop), .trig_pc(trig_pc),
        .trig_pc_en(trig_pc_en), .trig_excp_en(trig_excp_en), .rd_idx(rd_idx),
        .rd_pc(rd_pc1), .rd_stamp(rd_stamp1), .state(state1),
        .entry_cnt(entry_cnt1), .trig_seen(trig_seen1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic excp);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_excp  = excp;
        cycle();
        wb_valid = 1'b0;
        wb_excp  = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic read_at(input logic [3:0] idx);
        rd_idx = idx;
        cycle();
    endtask

    logic [15:0] s0, s1, sdiff;

    initial begin
        // Reset state
        cycle();
        cycle();
        chk("rst_state", state0, 0);
        chk("rst_cnt", entry_cnt0, 0);
        chk("rst_trig", trig_seen0, 0);
        chk("rst_rdpc", rd_pc0, 0);
        chk("rst_stamp", rd_stamp0, 0);
        resetn = 1'b1;
        cycle();

        // stop while IDLE is ignored
        pulse_stop();
        chk("idle_stop", state0, 0);

        // Fill and wrap
        pulse_arm();
        chk("arm_state", state0, 1);
        chk("arm_cnt", entry_cnt0, 0);
        for (int i = 0; i < 20; i++) commit(32'(i * 4), 1'b0);
        pulse_stop();
        chk("wrap_state", state0, 3);
        chk("wrap_cnt", entry_cnt0, 16);
        read_at(4'd0);
        chk("wrap_idx0", rd_pc0, 32'h10);
        read_at(4'd15);
        chk("wrap_idx15", rd_pc0, 32'h4C);
        read_at(4'd5);
        chk("wrap_idx5", rd_pc0, 32'h24);
        // DONE ignores further commits
        commit(32'h100, 1'b0);
        chk("done_cnt", entry_cnt0, 16);
        read_at(4'd15);
        chk("done_frozen", rd_pc0, 32'h4C);

        // Collisions
        arm = 1'b1;
        wb_valid = 1'b1;
        wb_pc = 32'h500;
        cycle();
        arm = 1'b0;
        wb_valid = 1'b0;
        chk("arm_valid_cnt", entry_cnt0, 0);
        chk("arm_valid_state", state0, 1);
        arm = 1'b1;
        stop = 1'b1;
        cycle();
        arm = 1'b0;
        stop = 1'b0;
        chk("arm_stop_state", state0, 1);

        // PC trigger at 0x20
        trig_pc = 32'h20;
        trig_pc_en = 1'b1;
        pulse_arm();
        for (int i = 0; i <= 8; i++) commit(32'(i * 4), 1'b0);
        chk("pct_post", state0, 2);
        chk("pct_trig", trig_seen0, 1);
        chk("pct_p0_done", state1, 3);
        for (int i = 9; i <= 16; i++) commit(32'(i * 4), 1'b0);
        chk("pct_done", state0, 3);
        chk("pct_cnt", entry_cnt0, 13);
        chk("pct_trig_hold", trig_seen0, 1);
        chk("pct_p0_cnt", entry_cnt1, 9);
        read_at(4'd12);
        chk("pct_last", rd_pc0, 32'h30);
        read_at(4'd13);
        chk("pct_past_end", rd_pc0, 0);
        read_at(4'd8);
        chk("pct_trig_entry", rd_pc0, 32'h20);
        chk("pct_p0_newest", rd_pc1, 32'h20);
        trig_pc_en = 1'b0;

        // Exception trigger, POST_DEPTH = 0
        trig_excp_en = 1'b1;
        pulse_arm();
        chk("ex_rearm_trig", trig_seen1, 0);
        commit(32'h10, 1'b0);
        commit(32'h14, 1'b0);
        commit(32'h18, 1'b0);
        chk("ex_armed", state1, 1);
        commit(32'h1C, 1'b1);
        chk("ex_done", state1, 3);
        chk("ex_trig", trig_seen1, 1);
        commit(32'h20, 1'b0);
        chk("ex_cnt", entry_cnt1, 4);
        chk("ex_main_cnt", entry_cnt0, 5);
        read_at(4'd3);
        chk("ex_newest", rd_pc1, 32'h1C);
        trig_excp_en = 1'b0;

        // Out-of-range read
        pulse_arm();
        commit(32'hA0, 1'b0);
        commit(32'hA4, 1'b0);
        commit(32'hA8, 1'b0);
        pulse_stop();
        chk("oor_cnt", entry_cnt0, 3);
        read_at(4'd2);
        chk("oor_in", rd_pc0, 32'hA8);
        read_at(4'd5);
        chk("oor_pc", rd_pc0, 0);
        chk("oor_stamp", rd_stamp0, 0);
        chk("oor_p0_pc", rd_pc1, 0);

        // Cycle stamps: two commits 7 cycles apart
        pulse_arm();
        commit(32'hC0, 1'b0);
        for (int i = 0; i < 6; i++) cycle();
        commit(32'hC4, 1'b0);
        pulse_stop();
        read_at(4'd0);
        s0 = rd_stamp0;
        read_at(4'd1);
        s1 = rd_stamp0;
        chk("stamp_pc1", rd_pc0, 32'hC4);
`ifdef TRACE_CYCLE_STAMP_EN
        sdiff = s1 - s0;
        chk("stamp_delta", 32'(sdiff), 7);
`else
        chk("stamp_off0", 32'(s0), 0);
        chk("stamp_off1", 32'(s1), 0);
`endif

        // Reset in the middle of POST
        trig_pc = 32'h300;
        trig_pc_en = 1'b1;
        rd_idx = 4'd0;
        pulse_arm();
        commit(32'h300, 1'b0);
        commit(32'h304, 1'b0);
        chk("mid_post", state0, 2);
        chk("mid_rdpc", rd_pc0, 32'h300);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_state", state0, 0);
        chk("async_cnt", entry_cnt0, 0);
        chk("async_trig", trig_seen0, 0);
        chk("async_rdpc", rd_pc0, 0);
        cycle();
        resetn = 1'b1;
        commit(32'h300, 1'b0);
        commit(32'h308, 1'b0);
        chk("post_rst_state", state0, 0);
        chk("post_rst_cnt", entry_cnt0, 0);
        chk("post_rst_trig", trig_seen0, 0);
        chk("post_rst_rdpc", rd_pc0, 0);
        pulse_arm();
        chk("post_rst_arm", state0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Parametrised, synthesizable commit-trace capture unit for the five-stage pipeline CPU. It snoops the write-back stage (retiring PC, valid, exception flag) and records retired PCs into a circular buffer. A PC-match or exception trigger freezes the buffer a programmable number of commits later. Readout uses an indexed port, in the same style as the CPU's `rf_addr`/`mem_addr` debug ports, so a bench or display wrapper can dump the history leading up to a fault.

## Interface
Parameters:
- `DEPTH`, 16 — number of trace entries; must be a power of two, range 4–256.
- `PC_W`, 32 — width of the captured PC.
- `POST_DEPTH`, 4 — commits captured after the trigger entry; range 0 to `DEPTH-1`.
- `AW` — derived, equal to log2(`DEPTH`); not user-set.

Ports:
- `clk` — in, 1, single clock; all state changes on the rising edge.
- `resetn` — in, 1, asynchronous active-low reset.
- `wb_valid` — in, 1, a valid instruction retires this cycle.
- `wb_pc` — in, `PC_W`, PC of the retiring instruction.
- `wb_excp` — in, 1, the retiring instruction raised an exception (CP0 entry).
- `arm` — in, 1, one-cycle pulse: clear the buffer and start capture.
- `stop` — in, 1, one-cycle pulse: force the `DONE` state immediately.
- `trig_pc` — in, `PC_W`, PC-match trigger value.
- `trig_pc_en` — in, 1, enables the PC-match trigger.
- `trig_excp_en` — in, 1, enables the exception trigger.
- `rd_idx` — in, `AW`, readout index; 0 is the oldest entry.
- `rd_pc` — out, `PC_W`, registered PC read from entry `rd_idx`.
- `rd_stamp` — out, 16, registered cycle stamp of entry `rd_idx`.
- `state` — out, 2, current state: 0 = `IDLE`, 1 = `ARMED`, 2 = `POST`, 3 = `DONE`.
- `entry_cnt` — out, `AW+1`, number of valid entries, 0 to `DEPTH`.
- `trig_seen` — out, 1, set when a trigger fired; cleared by `arm`.

## Operation
- A capture happens when `wb_valid` is 1 and state is `ARMED` or `POST`. Each capture:
  - writes the entry at `wr_ptr`;
  - advances `wr_ptr` modulo `DEPTH`;
  - updates `entry_cnt` to min(`entry_cnt`+1, `DEPTH`).
  - Once the buffer is full, each capture overwrites the oldest entry.
- Trigger condition, evaluated only in `ARMED` and only on a capture cycle: (`trig_pc_en` and `wb_pc` equals `trig_pc`) or (`trig_excp_en` and `wb_excp`).
- State transitions:
  - `IDLE` → `ARMED` on `arm`.
  - `ARMED` → `POST` on trigger. The trigger instruction is captured, `post_left` is loaded with `POST_DEPTH`, and `trig_seen` is set.
  - `ARMED` → `DONE` on trigger when `POST_DEPTH` is 0.
  - In `POST`, each capture decrements `post_left`. The capture that brings `post_left` to 0 moves the state to `DONE`.
  - `DONE` holds. Captures are ignored and the contents are frozen.
- `arm` in any state: `wr_ptr`, `entry_cnt` and `trig_seen` are cleared, the state goes to `ARMED`, and no capture happens that cycle even if `wb_valid` is 1.
- `stop` in any state other than `IDLE`: the state goes to `DONE` and no capture happens that cycle. If `arm` and `stop` arrive in the same cycle, `arm` wins.
- Readout:
  - The physical entry read is (`wr_ptr` − `entry_cnt` + `rd_idx`) mod `DEPTH`.
  - If `rd_idx` ≥ `entry_cnt`, `rd_pc` and `rd_stamp` return 0.
  - Readout is legal in every state. Its value is only stable in `DONE` and `IDLE`.
- All pointer arithmetic is `AW` bits wide and wraps naturally.

## Timing
- Reset values: `state` = `IDLE`, `entry_cnt` = 0, `trig_seen` = 0, `rd_pc` = 0, `rd_stamp` = 0, `wr_ptr` = 0, `post_left` = 0, stamp counter = 0. Buffer RAM contents are not reset.
- A capture becomes visible in `entry_cnt` in the cycle after the edge on which it is sampled.
- `rd_pc` and `rd_stamp` have 1-cycle latency: they reflect the `rd_idx` and buffer contents sampled at the previous edge.
- `state` changes on the same edge that samples the trigger or `arm`/`stop`, so `state` reads `POST` or `DONE` in the cycle after.
- Asserting `resetn` low in the middle of a capture returns all outputs to their reset values asynchronously.

## Configuration
- `TRACE_CYCLE_STAMP_EN` defined:
  - A free-running 16-bit cycle counter runs from reset and wraps at 0xFFFF → 0.
  - Its value is stored with every entry and returned on `rd_stamp`.
- `TRACE_CYCLE_STAMP_EN` not defined:
  - No counter or stamp storage is built.
  - `rd_stamp` is tied to 0. The port list is unchanged.

## Test plan
- Fill and wrap, `DEPTH`=16: `arm`, then 20 commits with PC 0x0, 0x4, …, 0x4C, then `stop` → `entry_cnt` = 16, `rd_idx` 0 reads 0x10, `rd_idx` 15 reads 0x4C.
- PC trigger, `POST_DEPTH`=4: `trig_pc` = 0x20, `trig_pc_en` = 1, commits 0x0…0x40 → `DONE` after the commit of 0x30, `entry_cnt` = 13, `trig_seen` = 1, last entry is 0x30, and the 0x34 commit is not stored.
- Exception trigger with `POST_DEPTH`=0: `wb_excp` = 1 on PC 0x1C → `DONE` on the next cycle, with 0x1C as the newest entry.
- Collision: `arm` and `wb_valid` in the same cycle → `entry_cnt` stays 0. `arm` and `stop` in the same cycle → `state` = `ARMED`.
- Reset mid-`POST`: drop `resetn` low between edges → `state`, `entry_cnt`, `trig_seen` and `rd_pc` are 0 immediately, and stay 0 after release until `arm`.
- Out-of-range read: `entry_cnt` = 3, `rd_idx` = 5 → `rd_pc` = 0 one cycle later. With `TRACE_CYCLE_STAMP_EN`, two commits 7 cycles apart show a `rd_stamp` difference of 7.
